// File: rtl/cla_pkg.sv
// Shared definitions for the segmented carry-lookahead adder/subtractor.
package cla_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Number of BLOCK-wide segments that make up a WIDTH-bit operand.
  function automatic int nseg_of(input int width, input int block);
    return width / block;
  endfunction

  // Width of the segment index; at least one bit even for a single segment.
  function automatic int seg_w_of(input int width, input int block);
    int n;
    n = width / block;
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Legal parameter combinations: non-empty slice that tiles the operand exactly.
  function automatic bit params_ok(input int width, input int block);
    if (block < 1) return 1'b0;
    if (width < block) return 1'b0;
    return (width % block) == 0;
  endfunction

endpackage

// File: rtl/cla_block.sv
// Combinational BLOCK-bit carry-lookahead slice with flattened carry equations.
module cla_block #(
  parameter int BLOCK = 8
) (
  input  logic [BLOCK-1:0] x,
  input  logic [BLOCK-1:0] y,
  input  logic             ci,
  output logic [BLOCK-1:0] s,
  output logic             co,
  output logic             c_msb
);

  logic [BLOCK-1:0] p;
  logic [BLOCK-1:0] g;
  logic [BLOCK:0]   c;

  assign p = x ^ y;
  assign g = x & y;

  // Each carry is expanded into its full sum-of-products form so no carry waits on another.
  always_comb begin
    logic acc;
    logic prop;
    acc  = 1'b0;
    prop = 1'b1;
    c    = '0;
    c[0] = ci;
    for (int i = 0; i < BLOCK; i++) begin
      acc  = 1'b0;
      prop = 1'b1;
      for (int j = i; j >= 0; j--) begin
        acc  = acc | (prop & g[j]);
        prop = prop & p[j];
      end
      c[i+1] = acc | (prop & ci);
    end
  end

  assign s     = p ^ c[BLOCK-1:0];
  assign co    = c[BLOCK];
  assign c_msb = c[BLOCK-1];

endmodule

// File: rtl/seg_cla_addsub.sv
// Multi-cycle adder/subtractor: one BLOCK-bit lookahead segment per clock, carry kept in a register.
module seg_cla_addsub
  import cla_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int BLOCK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);

  localparam int NSEG  = nseg_of(WIDTH, BLOCK);
  localparam int SEG_W = seg_w_of(WIDTH, BLOCK);

  if (!params_ok(WIDTH, BLOCK)) begin : g_bad_params
    $error("seg_cla_addsub: WIDTH must be a non-zero multiple of BLOCK");
  end

  state_t           state_q, state_d;
  logic [SEG_W-1:0] seg_q, seg_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] part_q, part_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             cout_q, cout_d;
  logic             overflow_q, overflow_d;
  logic             zero_q, zero_d;

  logic [BLOCK-1:0] x_seg, y_seg, s_seg;
  logic             co_seg, cmsb_seg;
  logic [WIDTH-1:0] merged;

  cla_block #(.BLOCK(BLOCK)) u_slice (
    .x     (x_seg),
    .y     (y_seg),
    .ci    (carry_q),
    .s     (s_seg),
    .co    (co_seg),
    .c_msb (cmsb_seg)
  );

  // Pick the current segment of each operand and splice the slice result into the partial result.
  always_comb begin
    int               seg_off;
    logic [WIDTH-1:0] a_shift;
    logic [WIDTH-1:0] b_shift;
    logic [WIDTH-1:0] seg_mask;
    seg_off  = BLOCK * int'(seg_q);
    a_shift  = a_q >> seg_off;
    b_shift  = b_q >> seg_off;
    x_seg    = a_shift[BLOCK-1:0];
    y_seg    = b_shift[BLOCK-1:0];
    seg_mask = WIDTH'({BLOCK{1'b1}}) << seg_off;
    merged   = (part_q & ~seg_mask) | (WIDTH'(s_seg) << seg_off);
  end

  // Next-state logic: accept a request when idle, otherwise walk the segments and publish at the last one.
  always_comb begin
    state_d    = state_q;
    seg_d      = seg_q;
    a_d        = a_q;
    b_d        = b_q;
    part_d     = part_q;
    sum_d      = sum_q;
    carry_d    = carry_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    cout_d     = cout_q;
    overflow_d = overflow_q;
    zero_d     = zero_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub ? ~cin : cin;
          seg_d   = '0;
          part_d  = '0;
          busy_d  = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        part_d  = merged;
        carry_d = co_seg;
        if (seg_q == SEG_W'(NSEG - 1)) begin
          sum_d      = merged;
          cout_d     = co_seg;
          overflow_d = cmsb_seg ^ co_seg;
          zero_d     = (merged == '0);
          done_d     = 1'b1;
          busy_d     = 1'b0;
          seg_d      = '0;
          state_d    = IDLE;
        end else begin
          seg_d = seg_q + SEG_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset discards any in-flight operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      seg_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      part_q     <= '0;
      sum_q      <= '0;
      carry_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      cout_q     <= 1'b0;
      overflow_q <= 1'b0;
      zero_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      seg_q      <= seg_d;
      a_q        <= a_d;
      b_q        <= b_d;
      part_q     <= part_d;
      sum_q      <= sum_d;
      carry_q    <= carry_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      cout_q     <= cout_d;
      overflow_q <= overflow_d;
      zero_q     <= zero_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign sum      = sum_q;
  assign cout     = cout_q;
  assign overflow = overflow_q;
  assign zero     = zero_q;

endmodule

// File: tb/tb_seg_cla_addsub.sv
// Directed bench for seg_cla_addsub: a 32/8 instance and a single-segment 8/8 instance.
module tb_seg_cla_addsub;

  logic        clk;
  logic        rst;
  logic        start, sub, cin;
  logic [31:0] a, b;
  logic        busy, done, cout, overflow, zero;
  logic [31:0] sum;

  logic        start8, sub8, cin8;
  logic [7:0]  a8, b8;
  logic        busy8, done8, cout8, overflow8, zero8;
  logic [7:0]  sum8;

  int testsRun;
  int testsFailed;

  seg_cla_addsub #(.WIDTH(32), .BLOCK(8)) dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .overflow(overflow), .zero(zero)
  );

  seg_cla_addsub #(.WIDTH(8), .BLOCK(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .sub(sub8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .overflow(overflow8), .zero(zero8)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Counts one comparison and reports it when observed and expected differ.
  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Compares the 32-bit result and flags against hand-computed values.
  task automatic checkResult(input string tag, input logic [31:0] expSum, input logic expCout,
                             input logic expOvf, input logic expZero);
    checkOutput({tag, ".sum"}, 64'(sum), 64'(expSum));
    checkOutput({tag, ".cout"}, 64'(cout), 64'(expCout));
    checkOutput({tag, ".ovf"}, 64'(overflow), 64'(expOvf));
    checkOutput({tag, ".zero"}, 64'(zero), 64'(expZero));
  endtask

  // Independent 33-bit reference: returns {overflow, cout, sum}.
  function automatic logic [33:0] refModel(input logic [31:0] ra, input logic [31:0] rb,
                                           input logic rs, input logic rc);
    logic [31:0] bb;
    logic        cc;
    logic [32:0] full;
    logic        ovf;
    bb   = rs ? ~rb : rb;
    cc   = rs ? ~rc : rc;
    full = {1'b0, ra} + {1'b0, bb} + 33'(cc);
    ovf  = (ra[31] == bb[31]) && (full[31] != ra[31]);
    return {ovf, full[32], full[31:0]};
  endfunction

  // Issues one operation on the 32-bit DUT and waits (bounded) for done; optionally pokes start mid-flight.
  task automatic applyStimulus(input logic [31:0] ta, input logic [31:0] tb, input logic ts,
                               input logic tc, input bit inject, output int cycles, output int busyCycles);
    a = ta; b = tb; sub = ts; cin = tc; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cycles = 0;
    busyCycles = 0;
    while (done !== 1'b1 && cycles < 20) begin
      if (busy === 1'b1) busyCycles++;
      if (inject && cycles == 1) begin
        start = 1'b1; a = 32'hDEAD_0000; b = 32'h0000_BEEF; sub = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      cycles++;
    end
    start = 1'b0;
  endtask

  // Issues one operation on the single-segment DUT and checks latency and result.
  task automatic runOp8(input string tag, input logic [7:0] ta, input logic [7:0] tb, input logic ts,
                        input logic tc, input logic [7:0] expSum, input logic expCout, input logic expOvf);
    int cycles;
    a8 = ta; b8 = tb; sub8 = ts; cin8 = tc; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    cycles = 0;
    checkOutput({tag, ".busy"}, 64'(busy8), 64'd1);
    while (done8 !== 1'b1 && cycles < 10) begin
      @(posedge clk); #1;
      cycles++;
    end
    checkOutput({tag, ".lat"}, 64'(cycles), 64'd1);
    checkOutput({tag, ".res"}, {54'd0, overflow8, cout8, zero8, sum8},
                {54'd0, expOvf, expCout, (expSum == 8'h00), expSum});
  endtask

  initial begin
    int cycles, busyCycles;
    logic [33:0] r;
    logic [31:0] ra, rb;
    logic rs, rc;
    bit sawDone;

    testsRun = 0;
    testsFailed = 0;
    rst = 1'b1;
    start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
    start8 = 1'b0; sub8 = 1'b0; cin8 = 1'b0; a8 = '0; b8 = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset.outs", {26'd0, busy, done, cout, overflow, zero, 1'b0, sum}, 64'd0);
    checkOutput("reset.outs8", {50'd0, busy8, done8, cout8, overflow8, zero8, 1'b0, sum8}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // Wrap-around add with latency and busy-width checks.
    applyStimulus(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0, cycles, busyCycles);
    checkOutput("wrap.lat", 64'(cycles), 64'd4);
    checkOutput("wrap.busy", 64'(busyCycles), 64'd4);
    checkResult("wrap", 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    @(posedge clk); #1;
    checkOutput("wrap.donePulse", 64'(done), 64'd0);
    checkOutput("wrap.hold", 64'(sum), 64'd0);

    applyStimulus(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0, cycles, busyCycles);
    checkResult("addOvf", 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    applyStimulus(32'h0000_FFFF, 32'h0000_0000, 1'b0, 1'b1, 1'b0, cycles, busyCycles);
    checkResult("addCin", 32'h0001_0000, 1'b0, 1'b0, 1'b0);
    applyStimulus(32'd5, 32'd7, 1'b1, 1'b0, 1'b0, cycles, busyCycles);
    checkResult("sub5m7", 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    applyStimulus(32'h8000_0000, 32'd1, 1'b1, 1'b0, 1'b0, cycles, busyCycles);
    checkResult("subOvf", 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
    applyStimulus(32'd10, 32'd3, 1'b1, 1'b1, 1'b0, cycles, busyCycles);
    checkResult("subBorrow", 32'd6, 1'b1, 1'b0, 1'b0);

    // Start pulsed mid-operation must be ignored.
    applyStimulus(32'd1, 32'd2, 1'b0, 1'b0, 1'b1, cycles, busyCycles);
    checkOutput("ignore.lat", 64'(cycles), 64'd4);
    checkResult("ignore", 32'd3, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    checkOutput("ignore.idle", 64'(busy), 64'd0);

    // Back-to-back: second start issued in the done cycle of the first.
    applyStimulus(32'h0000_0100, 32'h0000_0200, 1'b0, 1'b0, 1'b0, cycles, busyCycles);
    checkResult("b2b.first", 32'h0000_0300, 1'b0, 1'b0, 1'b0);
    applyStimulus(32'h0000_0010, 32'h0000_0020, 1'b0, 1'b0, 1'b0, cycles, busyCycles);
    checkOutput("b2b.lat", 64'(cycles), 64'd4);
    checkResult("b2b.second", 32'h0000_0030, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of an operation (seg = 2).
    a = 32'h1111_1111; b = 32'h2222_2222; sub = 1'b0; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    checkOutput("midReset.outs", {26'd0, busy, done, cout, overflow, zero, 1'b0, sum}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    sawDone = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) sawDone = 1'b1;
    end
    checkOutput("midReset.noDone", 64'(sawDone), 64'd0);
    applyStimulus(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 1'b0, cycles, busyCycles);
    checkOutput("afterReset.lat", 64'(cycles), 64'd4);
    checkResult("afterReset", 32'h2345_6789, 1'b0, 1'b0, 1'b0);

    // Pseudo-random vectors against the behavioural reference.
    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      rb = (i % 4 == 0) ? ra : $urandom;
      rs = 1'($urandom_range(0, 1));
      rc = 1'($urandom_range(0, 1));
      r  = refModel(ra, rb, rs, rc);
      applyStimulus(ra, rb, rs, rc, 1'b0, cycles, busyCycles);
      checkOutput("rand.lat", 64'(cycles), 64'd4);
      checkOutput("rand.res", {29'd0, overflow, cout, zero, sum},
                  {29'd0, r[33], r[32], (r[31:0] == 32'd0), r[31:0]});
    end

    // Single-segment instance: done follows the edge right after acceptance.
    runOp8("w8.wrap", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    runOp8("w8.ovf", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
    runOp8("w8.sub", 8'h05, 8'h07, 1'b1, 1'b0, 8'hFE, 1'b0, 1'b0);
    runOp8("w8.subOvf", 8'h80, 8'h01, 1'b1, 1'b0, 8'h7F, 1'b1, 1'b1);
    runOp8("w8.subCin", 8'h0A, 8'h03, 1'b1, 1'b1, 8'h06, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/seg_cla_addsub.md
Name: seg_cla_addsub

Overview:
- Parametrised, multi-cycle carry-lookahead adder/subtractor.
- Processes one BLOCK-bit lookahead segment per clock and carries the segment carry in a register, so wide operands take WIDTH/BLOCK cycles with one small CLA slice.
- Adds subtract mode, start/busy/done handshake, and carry/overflow/zero flags.
- Used as the shared ALU arithmetic unit in place of fixed-width combinational lookahead adders.

Parameters:
- WIDTH, 32: operand/result width. Must be a multiple of BLOCK and >= BLOCK.
- BLOCK, 8: lookahead slice width in bits, i.e. bits processed per cycle.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request a new operation; sampled only when idle.
- sub  in  1  0 = add (a+b+cin), 1 = subtract (a-b-cin, where cin is the borrow-in).
- a  in  WIDTH  operand A; captured on the accepted start.
- b  in  WIDTH  operand B; captured on the accepted start.
- cin  in  1  carry-in (add) or borrow-in (sub); captured on the accepted start.
- busy  out  1  high while an operation is in flight.
- done  out  1  one-cycle pulse; result and flags are valid from this cycle.
- sum  out  WIDTH  result.
- cout  out  1  raw carry out of the MSB. In sub mode, 1 = no borrow.
- overflow  out  1  two's-complement overflow: carry into MSB XOR carry out of MSB.
- zero  out  1  sum == 0.

Behaviour:
- NSEG = WIDTH/BLOCK. Internal state is IDLE or BUSY, plus a segment index seg in 0..NSEG-1.
- Reset (asynchronous, any time, including mid-operation):
  - State becomes IDLE, seg = 0.
  - busy, done, sum, cout, overflow, zero all 0; internal operand/carry registers 0.
  - An in-flight operation is discarded and no done is issued.
- IDLE accepting start:
  - Latch A = a and B' = sub ? ~b : b.
  - Latch carry = sub ? ~cin : cin.
  - Go to BUSY with seg = 0; busy rises at this edge.
- BUSY, every cycle:
  - The CLA slice computes A[seg], B'[seg] and carry for segment seg (BLOCK bits).
  - The slice result is written into the partial-result register at segment seg.
  - carry <= slice carry-out.
  - seg increments.
- Last segment (seg = NSEG-1), at that edge:
  - sum <= full partial result, with the last segment included.
  - cout <= slice carry-out.
  - overflow <= slice carry-into-top-bit XOR slice carry-out.
  - zero <= (full result == 0).
  - done <= 1, busy <= 0, state returns to IDLE.
- Latency: start accepted at edge E0, then done high in the cycle after edge E_NSEG. For NSEG = 1, done follows the edge right after acceptance.
- done is high for exactly one cycle. sum and flags hold their values until the next completion or reset.
- start while busy is ignored, with no queuing. Operand changes while busy have no effect.
- start during the done cycle is accepted, because the state is already IDLE. This gives back-to-back throughput of one result per NSEG cycles.
- Arithmetic is modulo 2^WIDTH. sum is never partially updated, so intermediate segments are not visible on sum.

Decomposition:
- Package cla_pkg holds:
  - State enum {IDLE, BUSY}.
  - A function computing NSEG and seg-index width (clog2(NSEG), minimum 1).
  - Elaboration-time checks that WIDTH % BLOCK == 0 and BLOCK >= 1.
- Sub-module cla_block (combinational, param BLOCK):
  - Inputs: x, y, ci.
  - Outputs: s, co, c_msb (carry into the top bit of the slice).
  - Built from per-bit p = x^y and g = x&y with full lookahead carries c[i+1] = g[i] | p[i]&c[i], flattened.
- Top level holds only registers, the FSM and segment muxing.

Test Plan (WIDTH=32, BLOCK=8 unless noted):
- Add with wrap: add 0xFFFFFFFF + 0x00000001, cin=0 -> done exactly 4 cycles after the accepting edge; sum=0x00000000, cout=1, zero=1, overflow=0; busy high for 4 cycles.
- Add overflow: add 0x7FFFFFFF + 0x00000001 -> sum=0x80000000, overflow=1, cout=0, zero=0.
- Subtract with borrow: sub 5 - 7, cin=0 -> sum=0xFFFFFFFE, cout=0, overflow=0. Then sub 0x80000000 - 1 -> sum=0x7FFFFFFF, cout=1, overflow=1. Then sub 10 - 3, cin=1 -> sum=6.
- Handshake: pulse start again in cycle 2 of busy with different operands -> ignored, first result unchanged. Assert start in the done cycle -> accepted, second done 4 cycles later.
- Reset mid-operation: assert rst at seg=2 -> all outputs 0 immediately and no done pulse. A new start after release completes normally.
- Parameter sweep: for (WIDTH,BLOCK) = (8,8), (16,4), (64,16), 1000 random add/sub/cin vectors each. Compare sum, cout, overflow and zero against a behavioural (WIDTH+1)-bit reference. Check latency = WIDTH/BLOCK, including the single-segment case (8,8).
